// File: rtl/sl_tx_scheduler.sv
// Round-robin scheduler sharing one serial-link transmitter between NREQ requesters,
// with start-timeout supervision, a programmable inter-word gap and per-requester ack.
module sl_tx_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    parameter int CNTW    = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*32-1:0]      req_data,
    input  logic [NREQ*2-1:0]       req_mode,
    input  logic [7:0]              gap_len,
    output logic [NREQ-1:0]         ack,
    output logic                    err,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic [CNTW-1:0]         sent_cnt,
    input  logic                    tx_ready,
    output logic                    tx_enable,
    output logic [31:0]             tx_data,
    output logic [1:0]              tx_mode
);
    localparam int IDW = $clog2(NREQ);
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      gap_q, gap_d;
    logic [CNTW-1:0] sent_cnt_q, sent_cnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            tx_enable_q, tx_enable_d;
    logic [31:0]     tx_data_q, tx_data_d;
    logic [1:0]      tx_mode_q, tx_mode_d;

    logic            found;
    logic [IDW-1:0]  winner;
    int unsigned     cand;
    logic [31:0]     sel_data;
    logic [1:0]      sel_mode;

    // First set request after the last winner, wrapping modulo NREQ.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        cand     = 0;
        sel_data = '0;
        sel_mode = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (32'(ptr_q) + k) % NREQ;
            if (!found && req[IDW'(cand)]) begin
                found  = 1'b1;
                winner = IDW'(cand);
            end
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (winner == IDW'(i)) begin
                sel_data = req_data[32*i +: 32];
                sel_mode = req_mode[2*i +: 2];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_id_d  = grant_id_q;
        timer_d     = timer_q;
        gap_d       = gap_q;
        sent_cnt_d  = sent_cnt_q;
        tx_data_d   = tx_data_q;
        tx_mode_d   = tx_mode_q;
        ack_d       = '0;
        err_d       = 1'b0;
        tx_enable_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tx_ready && found) begin
                    ptr_d      = winner;
                    grant_id_d = winner;
                    tx_data_d  = sel_data;
                    tx_mode_d  = (sel_mode == 2'b11) ? 2'b10 : sel_mode;
                    state_d    = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                tx_enable_d = 1'b1;
                timer_d     = '0;
                state_d     = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!tx_ready) begin
                    state_d = S_WAIT_DONE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    ack_d[grant_id_q] = 1'b1;
                    err_d             = 1'b1;
                    gap_d             = gap_len;
                    state_d           = S_GAP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (tx_ready) begin
                    ack_d[grant_id_q] = 1'b1;
                    sent_cnt_d        = sent_cnt_q + CNTW'(1);
                    gap_d             = gap_len;
                    state_d           = S_GAP;
                end
            end
            S_GAP: begin
                // gap_len of 0 and 1 both leave a single GAP cycle
                if (gap_q <= 8'd1) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= IDW'(NREQ - 1);
            grant_id_q  <= '0;
            timer_q     <= '0;
            gap_q       <= '0;
            sent_cnt_q  <= '0;
            ack_q       <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            tx_enable_q <= 1'b0;
            tx_data_q   <= '0;
            tx_mode_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_id_q  <= grant_id_d;
            timer_q     <= timer_d;
            gap_q       <= gap_d;
            sent_cnt_q  <= sent_cnt_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            tx_enable_q <= tx_enable_d;
            tx_data_q   <= tx_data_d;
            tx_mode_q   <= tx_mode_d;
        end
    end

    assign ack       = ack_q;
    assign err       = err_q;
    assign grant_id  = grant_id_q;
    assign busy      = busy_q;
    assign sent_cnt  = sent_cnt_q;
    assign tx_enable = tx_enable_q;
    assign tx_data   = tx_data_q;
    assign tx_mode   = tx_mode_q;

endmodule
